// File: rtl/pgreq_arbiter_if.sv
// Handshake bundle between the page-requesting allocator ports, the page-request
// arbiter and the free-list manager. The arbiter uses the slave view; the
// environment (allocators plus free-list manager) uses the master view.
interface pgreq_arbiter_if #(
  parameter int ports  = 4,
  parameter int pg_asz = 10
);
  logic [ports-1:0]  par_srdy;
  logic [ports-1:0]  par_drdy;
  logic [ports-1:0]  parr_srdy;
  logic [ports-1:0]  parr_drdy;
  logic [pg_asz-1:0] parr_page;
  logic              fl_req_srdy;
  logic              fl_req_drdy;
  logic              fl_rsp_srdy;
  logic              fl_rsp_drdy;
  logic [pg_asz-1:0] fl_rsp_page;

  modport slave (
    input  par_srdy, parr_drdy, fl_req_drdy, fl_rsp_srdy, fl_rsp_page,
    output par_drdy, parr_srdy, parr_page, fl_req_srdy, fl_rsp_drdy
  );

  modport master (
    output par_srdy, parr_drdy, fl_req_drdy, fl_rsp_srdy, fl_rsp_page,
    input  par_drdy, parr_srdy, parr_page, fl_req_srdy, fl_rsp_drdy
  );
endinterface

// File: rtl/pgreq_arbiter.sv
// Page-request arbiter: round-robin selects one allocator port per cycle to
// forward a page request to the free-list manager, remembers the requesting
// port in a tag FIFO, and steers each free-list response back to the port at
// the head of that FIFO so pages return strictly in issue order.
module pgreq_arbiter #(
  parameter int ports     = 4,
  parameter int pg_asz    = 10,
  parameter int tag_depth = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  pgreq_arbiter_if.slave            bus,
  output logic [$clog2(tag_depth):0] outstanding,
  output logic                      err_orphan
);

  localparam int idx_w = (ports > 1) ? $clog2(ports) : 1;
  localparam int ptr_w = $clog2(tag_depth);
  localparam int cnt_w = ptr_w + 1;

  localparam logic [idx_w-1:0] idx_zero = {idx_w{1'b0}};
  localparam logic [idx_w-1:0] idx_one  = idx_w'(32'd1);
  localparam logic [idx_w-1:0] idx_last = idx_w'(ports - 1);
  localparam logic [ptr_w-1:0] ptr_zero = {ptr_w{1'b0}};
  localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(32'd1);
  localparam logic [cnt_w-1:0] cnt_zero = {cnt_w{1'b0}};
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(32'd1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(tag_depth);

  // State
  logic [idx_w-1:0] rr_ptr_r;
  logic [ptr_w-1:0] wr_ptr_r;
  logic [ptr_w-1:0] rd_ptr_r;
  logic [cnt_w-1:0] count_r;
  logic             err_orphan_r;
  logic [idx_w-1:0] tag_mem_r [tag_depth];

  // Combinational
  logic [idx_w-1:0]  rr_eff_s;
  logic [cnt_w-1:0]  count_eff_s;
  logic              empty_s;
  logic              full_s;
  logic              any_req_s;
  logic              found_s;
  logic [idx_w-1:0]  winner_s;
  logic [idx_w-1:0]  cand_s;
  logic [idx_w-1:0]  head_tag_s;
  logic              req_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [ports-1:0]  par_drdy_s;
  logic [ports-1:0]  parr_srdy_s;
  logic              fl_rsp_drdy_s;
  logic [pg_asz-1:0] page_s;

  // While reset is held the outputs are driven from the reset state rather
  // than from whatever the registers held before the first reset edge.
  assign rr_eff_s    = reset ? idx_zero : rr_ptr_r;
  assign count_eff_s = reset ? cnt_zero : count_r;
  assign empty_s     = (count_eff_s == cnt_zero);
  assign full_s      = (count_eff_s == cnt_full);
  assign any_req_s   = |bus.par_srdy;
  assign head_tag_s  = tag_mem_r[rd_ptr_r];

  // Round-robin search: first requesting port at or above rr_ptr, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = idx_zero;
    cand_s   = idx_zero;
    for (int i = 0; i < ports; i++) begin
      cand_s = idx_w'((int'(rr_eff_s) + i) % ports);
      if (!found_s && bus.par_srdy[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Request side: forward when someone asks and a tag slot is free; fullness
  // comes from the registered count so a same-cycle pop cannot open a slot.
  always_comb begin
    req_valid_s = any_req_s & ~full_s;
    push_s      = req_valid_s & bus.fl_req_drdy;
    par_drdy_s  = {ports{1'b0}};
    if (push_s && found_s) begin
      par_drdy_s[winner_s] = 1'b1;
    end else begin
      par_drdy_s = {ports{1'b0}};
    end
  end

  // Response side: only the port owning the head tag sees the response.
  always_comb begin
    parr_srdy_s   = {ports{1'b0}};
    fl_rsp_drdy_s = 1'b0;
    if (!empty_s) begin
      parr_srdy_s[head_tag_s] = bus.fl_rsp_srdy;
      fl_rsp_drdy_s           = bus.parr_drdy[head_tag_s];
    end else begin
      parr_srdy_s   = {ports{1'b0}};
      fl_rsp_drdy_s = 1'b0;
    end
    pop_s = bus.fl_rsp_srdy & fl_rsp_drdy_s;
  end

  // Arbitration pointer, FIFO pointers, occupancy and the sticky orphan flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r     <= idx_zero;
      wr_ptr_r     <= ptr_zero;
      rd_ptr_r     <= ptr_zero;
      count_r      <= cnt_zero;
      err_orphan_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_one;
        rr_ptr_r <= (winner_s == idx_last) ? idx_zero : (winner_s + idx_one);
      end else begin
        wr_ptr_r <= wr_ptr_r;
        rr_ptr_r <= rr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_one;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_one;
        2'b01:   count_r <= count_r - cnt_one;
        default: count_r <= count_r;
      endcase
      if (bus.fl_rsp_srdy && empty_s) begin
        err_orphan_r <= 1'b1;
      end else begin
        err_orphan_r <= err_orphan_r;
      end
    end
  end

  // Tag storage: records which port each issued request belongs to.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      tag_mem_r[wr_ptr_r] <= winner_s;
    end else begin
      tag_mem_r[wr_ptr_r] <= tag_mem_r[wr_ptr_r];
    end
  end

  assign page_s          = bus.fl_rsp_page;
  assign bus.parr_page   = page_s;
  assign bus.par_drdy    = par_drdy_s;
  assign bus.parr_srdy   = parr_srdy_s;
  assign bus.fl_req_srdy = req_valid_s;
  assign bus.fl_rsp_drdy = fl_rsp_drdy_s;
  assign outstanding     = count_r;
  assign err_orphan      = err_orphan_r;

endmodule

// File: doc/pgreq_arbiter.md
PGREQ_ARBITER -- requirements
Module: pgreq_arbiter

Interface
REQ-001 Parameter: ports, 4, number of page-requesting allocator ports (2..8).
REQ-002 Parameter: pg_asz, 10, page address width.
REQ-003 Parameter: tag_depth, 8, outstanding-request tag FIFO depth (power of 2, >=2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 par_srdy  input  ports  per-port page request valid.
REQ-007 par_drdy  output  ports  per-port page request accept.
REQ-008 parr_srdy  output  ports  per-port returned-page valid.
REQ-009 parr_drdy  input  ports  per-port returned-page accept.
REQ-010 parr_page  output  pg_asz  returned page number, shared by all ports.
REQ-011 fl_req_srdy  output  1  request to free-list manager valid.
REQ-012 fl_req_drdy  input  1  free-list manager accepts request.
REQ-013 fl_rsp_srdy  input  1  free-list page response valid.
REQ-014 fl_rsp_drdy  output  1  response accept.
REQ-015 fl_rsp_page  input  pg_asz  response page number.
REQ-016 outstanding  output  clog2(tag_depth)+1  requests issued, responses not yet delivered.
REQ-017 err_orphan  output  1  sticky: response arrived with no outstanding request.

Function
REQ-018 Request transfer occurs on a cycle where fl_req_srdy and fl_req_drdy are both 1.
REQ-019 fl_req_srdy = (any par_srdy bit) AND (tag FIFO not full); combinational.
REQ-020 Winner = first asserted par_srdy at or after rr_ptr, searching upward with wrap at ports-1 -> 0.
REQ-021 par_drdy has at most one bit set: winner bit, only when fl_req_drdy=1 and tag FIFO not full; all other bits 0.
REQ-022 On request transfer: push winner index into tag FIFO; rr_ptr <= (winner+1) mod ports.
REQ-023 No request transfer: rr_ptr holds.
REQ-024 Response path: when tag FIFO non-empty, parr_srdy[head_tag] = fl_rsp_srdy; other parr_srdy bits 0.
REQ-025 fl_rsp_drdy = parr_drdy[head_tag] when tag FIFO non-empty; parr_page = fl_rsp_page, no register stage.
REQ-026 Response transfer (fl_rsp_srdy & fl_rsp_drdy) pops tag FIFO head.
REQ-027 Responses are delivered strictly in request-issue order; no reordering between ports.
REQ-028 Simultaneous push and pop in one cycle: both take effect, outstanding unchanged.
REQ-029 Tag FIFO full (outstanding = tag_depth): fl_req_srdy=0, all par_drdy=0, until a pop.
REQ-030 Same-cycle pop when full does not enable push that cycle (full evaluated from registered count).
REQ-031 Tag FIFO empty with fl_rsp_srdy=1: fl_rsp_drdy=0, parr_srdy=0, err_orphan <= 1.
REQ-032 err_orphan stays 1 until reset.
REQ-033 outstanding = registered FIFO occupancy; increments on push only, decrements on pop only.
REQ-034 Read/write pointers wrap modulo tag_depth.

Reset
REQ-035 During reset: rr_ptr=0, tag FIFO empty, outstanding=0, err_orphan=0.
REQ-036 Outputs while reset=1 follow combinational rules on reset state: par_drdy depends on inputs, parr_srdy=0, fl_rsp_drdy=0.
REQ-037 Reset mid-operation discards all outstanding tags; responses arriving afterward flag err_orphan.

Verification
REQ-038 ports=4, par_srdy=4'b1111 held, fl_req_drdy=1 -> grants 0,1,2,3,0 on consecutive cycles; par_drdy one-hot.
REQ-039 par_srdy=4'b0101, rr_ptr=1 -> grant port 2, then port 0, then port 2.
REQ-040 Issue ports 3,1,3; return pages 0x11,0x22,0x33 -> port3 gets 0x11, port1 0x22, port3 0x33.
REQ-041 tag_depth=8, no responses, 9 requests offered -> 8 accepted, outstanding=8, fl_req_srdy=0; one pop -> next cycle 9th accepted.
REQ-042 Head tag port 2 with parr_drdy[2]=0 for 5 cycles -> fl_rsp_drdy=0, no pop, later requests still issue.
REQ-043 fl_rsp_srdy=1 with outstanding=0 -> fl_rsp_drdy=0, err_orphan=1 next cycle and held until reset.
